// File: rtl/xosera_pkg.sv
// rtl/xosera_pkg.sv - shared constants and types for the Xosera host bus bridge
//
// Purpose: host bus pin polarities, bridge parameter defaults and the bridge
//          FSM state type, shared by the bridge and its synchronizer.
// Ports:   none (package).

package xosera_pkg;

  // Host bus pin polarities
  localparam logic CS_ENABLED  = 1'b0;   // chip select asserted level
  localparam logic CS_DISABLED = 1'b1;
  localparam logic RnW_READ    = 1'b1;   // rd_nwr level for a read
  localparam logic RnW_WRITE   = 1'b0;

  // Bridge parameter defaults
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int DTACK_DELAY_DEFAULT = 1;

  // Bridge FSM states
  typedef enum logic [2:0] {
    BR_IDLE    = 3'd0,
    BR_SETTLE  = 3'd1,
    BR_STROBE  = 3'd2,
    BR_DELAY   = 3'd3,
    BR_ACK     = 3'd4,
    BR_RELEASE = 3'd5
  } bridge_state_t;

endpackage

// File: rtl/xosera_sync.sv
// rtl/xosera_sync.sv - N-stage single-bit synchronizer with reset value
//
// Purpose: brings an asynchronous host pin into the clk domain.
// Ports:
//   clk      in  clock
//   reset_i  in  synchronous active-high reset; loads RESET_VAL into every stage
//   d        in  asynchronous input
//   q        out synchronized output (last stage)

module xosera_sync #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_i,
  input  logic d,
  output logic q
);

  logic [N-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sr <= {N{RESET_VAL}};
    end else begin
      sr <= {sr[N-2:0], d};
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/xosera_bus_bridge.sv
// rtl/xosera_bus_bridge.sv - asynchronous host bus to core register bridge
//
// Purpose: synchronizes host chip select and read/write, latches the access
//          fields, issues a single-cycle read or write strobe to the core,
//          captures read data and drives a delayed transfer acknowledge.
// Ports:
//   clk             in  sole clock
//   reset_i         in  synchronous active-high reset
//   bus_cs_n_i      in  async chip select, active low
//   bus_rd_nwr_i    in  async read/not-write
//   bus_reg_num_i   in  register number
//   bus_bytesel_i   in  byte select (odd byte = 1), unused on a 16-bit bus
//   bus_data_i      in  host write data
//   bus_data_o      out registered host read data
//   bus_out_ena_o   out host data tri-state enable (combinational)
//   bus_dtack_o     out transfer acknowledge, active high
//   reg_data_i      in  core read data, valid the cycle after read_strobe_o
//   write_strobe_o  out single-cycle write strobe
//   read_strobe_o   out single-cycle read strobe
//   reg_num_o       out latched register number
//   bytesel_o       out latched byte select
//   bytedata_o      out latched write data

module xosera_bus_bridge #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = xosera_pkg::SYNC_STAGES_DEFAULT,
  parameter int DTACK_DELAY = xosera_pkg::DTACK_DELAY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  bus_cs_n_i,
  input  logic                  bus_rd_nwr_i,
  input  logic [3:0]            bus_reg_num_i,
  input  logic                  bus_bytesel_i,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic                  bus_out_ena_o,
  output logic                  bus_dtack_o,
  input  logic [DATA_WIDTH-1:0] reg_data_i,
  output logic                  write_strobe_o,
  output logic                  read_strobe_o,
  output logic [3:0]            reg_num_o,
  output logic                  bytesel_o,
  output logic [DATA_WIDTH-1:0] bytedata_o
);

  import xosera_pkg::*;

  logic          cs_n_sync;
  logic          rd_nwr_sync;
  logic          cs_active;
  bridge_state_t state;
  bridge_state_t state_next;
  logic [2:0]    dly_cnt;
  logic [1:0]    fill_cnt;
  logic          need_release;
  logic          rd_pending;
  logic          latch_fields;
  logic          wr_strobe_next;
  logic          rd_strobe_next;
  logic          dtack_next;

  xosera_sync #(
    .N         (SYNC_STAGES),
    .RESET_VAL (CS_DISABLED)
  ) u_cs_sync (
    .clk     (clk),
    .reset_i (reset_i),
    .d       (bus_cs_n_i),
    .q       (cs_n_sync)
  );

  xosera_sync #(
    .N         (SYNC_STAGES),
    .RESET_VAL (RnW_READ)
  ) u_rnw_sync (
    .clk     (clk),
    .reset_i (reset_i),
    .d       (bus_rd_nwr_i),
    .q       (rd_nwr_sync)
  );

  assign cs_active = (cs_n_sync == CS_ENABLED);

  // Drive the host data bus only for a read in progress; deliberately raw
  // pins so the bus turns around as soon as the host lets go.
  assign bus_out_ena_o = !reset_i && (bus_cs_n_i == CS_ENABLED) && (bus_rd_nwr_i == RnW_READ);

  // After reset the synchronizers hold their preset (deasserted) value for
  // SYNC_STAGES cycles, which says nothing about the pin. fill_cnt marks when
  // the synchronizer output reflects the pin again; need_release blocks a new
  // access until a genuine deassertion of chip select has been observed.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      fill_cnt     <= 2'(SYNC_STAGES);
      need_release <= 1'b1;
    end else begin
      if (fill_cnt != 2'd0) begin
        fill_cnt <= fill_cnt - 2'd1;
      end
      if (fill_cnt == 2'd0 && !cs_active) begin
        need_release <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next     = state;
    latch_fields   = 1'b0;
    wr_strobe_next = 1'b0;
    rd_strobe_next = 1'b0;
    dtack_next     = 1'b0;
    case (state)
      BR_IDLE: begin
        if (cs_active && !need_release) begin
          state_next = BR_SETTLE;
        end
      end
      BR_SETTLE: begin
        if (cs_active) begin
          state_next     = BR_STROBE;
          latch_fields   = 1'b1;
          wr_strobe_next = (rd_nwr_sync != RnW_READ);
          rd_strobe_next = (rd_nwr_sync == RnW_READ);
        end else begin
          state_next = BR_IDLE;
        end
      end
      BR_STROBE: begin
        if (DTACK_DELAY == 0) begin
          state_next = BR_ACK;
          dtack_next = 1'b1;
        end else begin
          state_next = BR_DELAY;
        end
      end
      BR_DELAY: begin
        if (!cs_active) begin
          state_next = BR_RELEASE;
        end else if (dly_cnt == 3'd0) begin
          state_next = BR_ACK;
          dtack_next = 1'b1;
        end
      end
      BR_ACK: begin
        if (cs_active) begin
          dtack_next = 1'b1;
        end else begin
          state_next = BR_IDLE;
        end
      end
      BR_RELEASE: begin
        if (!cs_active) begin
          state_next = BR_IDLE;
        end
      end
      default: begin
        state_next = BR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state          <= BR_IDLE;
      dly_cnt        <= 3'd0;
      write_strobe_o <= 1'b0;
      read_strobe_o  <= 1'b0;
      bus_dtack_o    <= 1'b0;
      rd_pending     <= 1'b0;
      reg_num_o      <= 4'd0;
      bytesel_o      <= 1'b0;
      bytedata_o     <= '0;
      bus_data_o     <= '0;
    end else begin
      state          <= state_next;
      write_strobe_o <= wr_strobe_next;
      read_strobe_o  <= rd_strobe_next;
      bus_dtack_o    <= dtack_next;
      // Core read data arrives the cycle after the read strobe.
      rd_pending     <= read_strobe_o;

      if (state == BR_STROBE) begin
        dly_cnt <= 3'(DTACK_DELAY - 1);
      end else if (state == BR_DELAY && dly_cnt != 3'd0) begin
        dly_cnt <= dly_cnt - 3'd1;
      end

      if (latch_fields) begin
        reg_num_o  <= bus_reg_num_i;
        bytesel_o  <= (DATA_WIDTH == 16) ? 1'b0 : bus_bytesel_i;
        bytedata_o <= bus_data_i;
      end

      if (rd_pending) begin
        bus_data_o <= reg_data_i;
      end
    end
  end

endmodule
